i2c_lm75_target: RTL and testbench
==================================

// Module: i2c_lm75_target
// PURPOSE
//  Synthesizable I2C target (slave) modelling the LM75 register map; it answers the Master block's transactions.
//  Oversamples Scl/Sda with Clk_in, decodes START/STOP, address, pointer and data bytes.
//  Drives Sda open-drain for ACK and read data; never drives Scl (no clock stretching).
//  Sits on the shared pulled-up Scl/Sda bus beside the master; temperature comes from Temp_in.
// PARAMETERS
//  ADDR         7'h4D   7-bit target address (7'b1001101)
//  SYNC_STAGES  2       flops in Scl/Sda synchronizers (>=2)
//  TOS_RST      16'h5000 reset value of Tos register (80 C)
//  THYST_RST    16'h4B00 reset value of Thyst register (75 C)
// PORTS
//  Clk_in     in     1   system clock, 50 MHz
//  Rst        in     1   synchronous reset, active-high
//  Scl        in     1   I2C clock (bus, pulled up)
//  Sda        inout  1   I2C data; drive 1'b0 or 1'bz only
//  Temp_in    in     16  temperature, LM75 format (9 MSBs valid)
//  Conf_out   out    8   configuration register
//  Thyst_out  out    16  hysteresis register
//  Tos_out    out    16  over-temp register
//  Busy       out    1   high from address match until STOP/abort
//  Os         out    1   over-temp flag (only with OS_EN)
// BEHAVIOUR
//  Reset: Sda released (z), Conf_out=0, Thyst_out=THYST_RST, Tos_out=TOS_RST, pointer=0, Busy=0, Os=0, state IDLE.
//  Reset mid-transfer: Sda released on the next edge; bus traffic is ignored until the next START.
//  Sampling: Scl/Sda synchronized, then edge-detected; internal event lags the pin by SYNC_STAGES+1 cycles.
//   Spec minimum: Scl high and low phases >= 8 Clk_in cycles.
//  START = Sda fall while Scl high; STOP = Sda rise while Scl high; both are valid in any state.
//   START -> ADDR and bit counter cleared; STOP -> IDLE with Sda released and Busy=0.
//  Data is sampled on Scl rise; Sda is changed only on Scl fall; bit counter 7..0, MSB first.
//  States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WR, WR_ACK, RD, RD_ACK, WAIT_STOP.
//  ADDR: 8 bits shifted in. If addr!=ADDR -> WAIT_STOP (no ACK); else ADDR_ACK with Busy=1.
//  ADDR_ACK: Sda low from the 8th Scl fall to the 9th Scl fall. Then R/W=0 -> PTR, R/W=1 -> RD.
//   On RD entry the register at pointer is snapshotted; Temp_in is latched so MSB and LSB stay coherent.
//  PTR: if byte[7:2]!=0 -> NACK, WAIT_STOP; else pointer=byte[1:0], ACK, WR.
//  WR: byte index 0=MSB, 1=LSB, then wraps to 0. Each byte is ACKed.
//   ptr0 (temp): data ignored but ACKed.
//   ptr1 (conf): byte0 -> Conf_out; byte1 ignored.
//   ptr2/3: 16-bit reg updated atomically when LSB is ACKed; an MSB alone never commits.
//  RD: drive snapshot MSB then LSB (Sda z for 1, 0 for 0). ptr1 returns Conf then Conf.
//  RD_ACK: sample master ACK on 9th Scl rise. ACK -> next byte (LSB, then wraps to MSB). NACK -> WAIT_STOP, Sda z.
//  Repeated START between write and read keeps the pointer (pointer-preset read).
//  Simultaneous START/STOP detect and a data edge: START/STOP wins.
//  Register outputs change only on the Clk_in edge that commits them.
// CONFIGURATION
//  OS_EN defined: Os is set when Temp_in[15:7] > Tos_out[15:7] (signed).
//   Os is cleared when Temp_in[15:7] < Thyst_out[15:7].
//   Comparator mode; Conf_out[2] inverts Os polarity. Updated every cycle, registered (1-cycle latency).
//  OS_EN undefined: no comparator logic and Os tied 0; Conf_out[2] is stored only.
// TESTING
//  Write Adr=7'h4D, R_W=0, Pointer=8'h01, Data 8'hCD, 8'h32 -> 3 ACKs, Conf_out=8'hCD, Busy low after STOP.
//  Write ptr 8'h03, 8'h55, 8'hAA -> Tos_out=16'h55AA only after LSB ACK; STOP after MSB -> Tos unchanged.
//  Temp_in=16'h1900, write ptr 0, RS, read 2 bytes (ACK, NACK) -> 8'h19, 8'h00; Sda released after NACK.
//  Adr=7'h48 -> no ACK (Sda high on 9th clk), Busy stays 0, registers unchanged.
//  Pointer 8'h05 -> NACK; Rst pulse mid-read -> Sda z next cycle, pointer=0, next transfer OK.
//  OS_EN: Temp_in 16'h5100 -> Os=1; 16'h4C00 -> Os stays 1; 16'h4A00 -> Os=0.

Source files
------------

// File: rtl/i2c_lm75_target.sv
// LM75-style I2C target: oversampled Scl/Sda, START/STOP decode, pointer/Conf/Thyst/Tos map.
// Optional over-temperature comparator on Os is built only when OS_EN is defined.
module i2c_lm75_target #(
   parameter logic [6:0]  ADDR        = 7'h4D,
   parameter int          SYNC_STAGES = 2,
   parameter logic [15:0] TOS_RST     = 16'h5000,
   parameter logic [15:0] THYST_RST   = 16'h4B00
) (
   input  logic        Clk_in,
   input  logic        Rst,
   input  logic        Scl,
   inout  wire         Sda,
   input  logic [15:0] Temp_in,
   output logic [7:0]  Conf_out,
   output logic [15:0] Thyst_out,
   output logic [15:0] Tos_out,
   output logic        Busy,
   output logic        Os
);

   typedef enum logic [3:0] {
      S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK,
      S_WR, S_WR_ACK, S_RD, S_RD_ACK, S_WAIT_STOP
   } state_t;

   logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
   logic scl_prev_q, sda_prev_q;

   // Bus idles high, so synchronizers reset to 1 to avoid a spurious START.
   for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      always_ff @(posedge Clk_in) begin
         if (Rst) begin
            scl_sync_q[gi] <= 1'b1;
            sda_sync_q[gi] <= 1'b1;
         end else if (gi == 0) begin
            scl_sync_q[gi] <= Scl;
            sda_sync_q[gi] <= Sda;
         end else begin
            scl_sync_q[gi] <= scl_sync_q[(gi == 0) ? 0 : gi-1];
            sda_sync_q[gi] <= sda_sync_q[(gi == 0) ? 0 : gi-1];
         end
      end
   end

   logic scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;
   assign scl_s     = scl_sync_q[SYNC_STAGES-1];
   assign sda_s     = sda_sync_q[SYNC_STAGES-1];
   assign scl_rise  = scl_s & ~scl_prev_q;
   assign scl_fall  = ~scl_s & scl_prev_q;
   assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
   assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

   state_t      state_q, state_d;
   logic [2:0]  bit_cnt_q, bit_cnt_d;
   logic [7:0]  shift_q, shift_d;
   logic        got_byte_q, got_byte_d;
   logic        rw_q, rw_d;
   logic [1:0]  ptr_q, ptr_d;
   logic        byte_idx_q, byte_idx_d;
   logic [7:0]  msb_buf_q, msb_buf_d;
   logic [7:0]  conf_q, conf_d;
   logic [15:0] thyst_q, thyst_d, tos_q, tos_d;
   logic [15:0] snap_q, snap_d, snap_sel;
   logic        sda_oe_q, sda_oe_d;
   logic        busy_q, busy_d;
   logic [7:0]  rd_byte, rd_next_byte;
   logic        rx_byte_end;

   always_comb begin
      snap_sel = Temp_in;
      case (ptr_q)
         2'd1:    snap_sel = {conf_q, conf_q};
         2'd2:    snap_sel = thyst_q;
         2'd3:    snap_sel = tos_q;
         default: snap_sel = Temp_in;
      endcase
   end

   assign rd_byte      = byte_idx_q ? snap_q[7:0]  : snap_q[15:8];
   assign rd_next_byte = byte_idx_q ? snap_q[15:8] : snap_q[7:0];
   assign rx_byte_end  = scl_fall & got_byte_q;

   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      got_byte_d = got_byte_q;
      rw_d       = rw_q;
      ptr_d      = ptr_q;
      byte_idx_d = byte_idx_q;
      msb_buf_d  = msb_buf_q;
      conf_d     = conf_q;
      thyst_d    = thyst_q;
      tos_d      = tos_q;
      snap_d     = snap_q;
      sda_oe_d   = sda_oe_q;
      busy_d     = busy_q;

      // Shared byte receiver; the byte is acted on at the 8th Scl fall.
      if ((state_q == S_ADDR || state_q == S_PTR || state_q == S_WR) && scl_rise) begin
         shift_d = {shift_q[6:0], sda_s};
         if (bit_cnt_q == 3'd0) got_byte_d = 1'b1;
         else                   bit_cnt_d  = bit_cnt_q - 3'd1;
      end

      case (state_q)
         S_ADDR: if (rx_byte_end) begin
            got_byte_d = 1'b0;
            if (shift_q[7:1] == ADDR) begin
               rw_d     = shift_q[0];
               busy_d   = 1'b1;
               sda_oe_d = 1'b1;
               state_d  = S_ADDR_ACK;
            end else begin
               busy_d  = 1'b0;
               state_d = S_WAIT_STOP;
            end
         end
         S_ADDR_ACK: if (scl_fall) begin
            bit_cnt_d  = 3'd7;
            byte_idx_d = 1'b0;
            if (rw_q) begin
               snap_d   = snap_sel;
               sda_oe_d = ~snap_sel[15];
               state_d  = S_RD;
            end else begin
               sda_oe_d = 1'b0;
               state_d  = S_PTR;
            end
         end
         S_PTR: if (rx_byte_end) begin
            got_byte_d = 1'b0;
            if (shift_q[7:2] != 6'd0) begin
               state_d = S_WAIT_STOP;
            end else begin
               ptr_d    = shift_q[1:0];
               sda_oe_d = 1'b1;
               state_d  = S_PTR_ACK;
            end
         end
         S_PTR_ACK: if (scl_fall) begin
            sda_oe_d   = 1'b0;
            bit_cnt_d  = 3'd7;
            byte_idx_d = 1'b0;
            state_d    = S_WR;
         end
         S_WR: if (rx_byte_end) begin
            got_byte_d = 1'b0;
            sda_oe_d   = 1'b1;
            state_d    = S_WR_ACK;
            byte_idx_d = ~byte_idx_q;
            if (!byte_idx_q) begin
               msb_buf_d = shift_q;
               if (ptr_q == 2'd1) conf_d = shift_q;
            end else begin
               if (ptr_q == 2'd2) thyst_d = {msb_buf_q, shift_q};
               if (ptr_q == 2'd3) tos_d   = {msb_buf_q, shift_q};
            end
         end
         S_WR_ACK: if (scl_fall) begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = 3'd7;
            state_d   = S_WR;
         end
         S_RD: if (scl_fall) begin
            if (bit_cnt_q != 3'd0) begin
               bit_cnt_d = bit_cnt_q - 3'd1;
               sda_oe_d  = ~rd_byte[bit_cnt_q - 3'd1];
            end else begin
               sda_oe_d   = 1'b0;
               got_byte_d = 1'b0;
               state_d    = S_RD_ACK;
            end
         end
         S_RD_ACK: begin
            if (scl_rise) begin
               if (sda_s) state_d    = S_WAIT_STOP;
               else       got_byte_d = 1'b1;
            end else if (rx_byte_end) begin
               got_byte_d = 1'b0;
               byte_idx_d = ~byte_idx_q;
               bit_cnt_d  = 3'd7;
               sda_oe_d   = ~rd_next_byte[7];
               state_d    = S_RD;
            end
         end
         default: ;
      endcase

      if (start_det) begin
         state_d    = S_ADDR;
         bit_cnt_d  = 3'd7;
         got_byte_d = 1'b0;
         sda_oe_d   = 1'b0;
      end else if (stop_det) begin
         state_d  = S_IDLE;
         sda_oe_d = 1'b0;
         busy_d   = 1'b0;
      end
   end

   always_ff @(posedge Clk_in) begin
      if (Rst) begin
         scl_prev_q <= 1'b1;
         sda_prev_q <= 1'b1;
         state_q    <= S_IDLE;
         bit_cnt_q  <= 3'd7;
         shift_q    <= 8'd0;
         got_byte_q <= 1'b0;
         rw_q       <= 1'b0;
         ptr_q      <= 2'd0;
         byte_idx_q <= 1'b0;
         msb_buf_q  <= 8'd0;
         conf_q     <= 8'd0;
         thyst_q    <= THYST_RST;
         tos_q      <= TOS_RST;
         snap_q     <= 16'd0;
         sda_oe_q   <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         scl_prev_q <= scl_s;
         sda_prev_q <= sda_s;
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         got_byte_q <= got_byte_d;
         rw_q       <= rw_d;
         ptr_q      <= ptr_d;
         byte_idx_q <= byte_idx_d;
         msb_buf_q  <= msb_buf_d;
         conf_q     <= conf_d;
         thyst_q    <= thyst_d;
         tos_q      <= tos_d;
         snap_q     <= snap_d;
         sda_oe_q   <= sda_oe_d;
         busy_q     <= busy_d;
      end
   end

`ifdef OS_EN
   logic os_cmp_q, os_cmp_d, os_q;
   // Comparator with hysteresis on the 9 valid temperature bits, two's complement.
   always_comb begin
      os_cmp_d = os_cmp_q;
      if ($signed(Temp_in[15:7]) > $signed(tos_q[15:7]))
         os_cmp_d = 1'b1;
      else if ($signed(Temp_in[15:7]) < $signed(thyst_q[15:7]))
         os_cmp_d = 1'b0;
   end

   always_ff @(posedge Clk_in) begin
      if (Rst) begin
         os_cmp_q <= 1'b0;
         os_q     <= 1'b0;
      end else begin
         os_cmp_q <= os_cmp_d;
         os_q     <= os_cmp_d ^ conf_q[2];
      end
   end
   assign Os = os_q;
`else
   assign Os = 1'b0;
`endif

   assign Sda       = sda_oe_q ? 1'b0 : 1'bz;
   assign Conf_out  = conf_q;
   assign Thyst_out = thyst_q;
   assign Tos_out   = tos_q;
   assign Busy      = busy_q;

endmodule

// File: tb/tb_i2c_lm75_target.sv
// Directed bit-banged I2C master bench for i2c_lm75_target with hand-computed expectations.
// Exercises conf/Tos writes, pointer-preset reads, address/pointer NACKs and reset mid-read.
module tb_i2c_lm75_target;

   localparam int H = 20;  // Scl phase length in Clk_in cycles

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        scl = 1'b1;
   logic        sda_low = 1'b0;
   logic [15:0] temp_in = 16'h0000;
   wire         sda;
   logic [7:0]  conf_out;
   logic [15:0] thyst_out, tos_out;
   logic        busy, os;

   int n_checks = 0;
   int n_fail   = 0;

   assign sda = sda_low ? 1'b0 : 1'bz;
   pullup (sda);

   always #10 clk = ~clk;

   i2c_lm75_target dut (
      .Clk_in   (clk),
      .Rst      (rst),
      .Scl      (scl),
      .Sda      (sda),
      .Temp_in  (temp_in),
      .Conf_out (conf_out),
      .Thyst_out(thyst_out),
      .Tos_out  (tos_out),
      .Busy     (busy),
      .Os       (os)
   );

   task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic i2c_start();
      sda_low = 1'b0; wait_cyc(H/2);
      scl = 1'b1;     wait_cyc(H);
      sda_low = 1'b1; wait_cyc(H);
      scl = 1'b0;     wait_cyc(H/2);
   endtask

   task automatic i2c_stop();
      sda_low = 1'b1; wait_cyc(H/2);
      scl = 1'b1;     wait_cyc(H);
      sda_low = 1'b0; wait_cyc(H);
      $display("txn: STOP");
   endtask

   task automatic i2c_bit(input logic b, output logic s);
      sda_low = ~b; wait_cyc(H/2);
      scl = 1'b1;   wait_cyc(H/2);
      s = sda;      wait_cyc(H/2);
      scl = 1'b0;   wait_cyc(H/2);
   endtask

   task automatic wr_byte(input logic [7:0] d, output logic ack);
      logic s;
      for (int i = 7; i >= 0; i--) i2c_bit(d[i], s);
      i2c_bit(1'b1, s);
      ack = ~s;
      $display("txn: wr %h ack=%0b", d, ack);
   endtask

   task automatic rd_byte(input logic m_ack, output logic [7:0] d);
      logic s;
      for (int i = 7; i >= 0; i--) begin
         i2c_bit(1'b1, s);
         d[i] = s;
      end
      i2c_bit(~m_ack, s);
      $display("txn: rd %h master_ack=%0b", d, m_ack);
   endtask

   logic       ack;
   logic [7:0] rd;

   initial begin
      wait_cyc(5);
      rst = 1'b0;
      wait_cyc(5);
      check_val("rst_conf", {8'h00, conf_out}, 16'h0000);
      check_val("rst_thyst", thyst_out, 16'h4B00);
      check_val("rst_tos", tos_out, 16'h5000);
      check_val("rst_busy", {15'd0, busy}, 16'd0);
      check_val("rst_os", {15'd0, os}, 16'd0);
      check_val("rst_sda", {15'd0, sda}, 16'd1);

      // Conf write, second byte ignored
      i2c_start();
      wr_byte(8'h9A, ack); check_val("conf_addr_ack", {15'd0, ack}, 16'd1);
      check_val("conf_busy", {15'd0, busy}, 16'd1);
      wr_byte(8'h01, ack); check_val("conf_ptr_ack", {15'd0, ack}, 16'd1);
      wr_byte(8'hCD, ack); check_val("conf_d0_ack", {15'd0, ack}, 16'd1);
      wr_byte(8'h32, ack); check_val("conf_d1_ack", {15'd0, ack}, 16'd1);
      i2c_stop();
      check_val("conf_val", {8'h00, conf_out}, 16'h00CD);
      check_val("conf_busy_stop", {15'd0, busy}, 16'd0);

      // Tos commits only on the LSB
      i2c_start();
      wr_byte(8'h9A, ack);
      wr_byte(8'h03, ack);
      wr_byte(8'h55, ack); check_val("tos_msb_ack", {15'd0, ack}, 16'd1);
      check_val("tos_msb_only", tos_out, 16'h5000);
      wr_byte(8'hAA, ack); check_val("tos_lsb_ack", {15'd0, ack}, 16'd1);
      check_val("tos_commit", tos_out, 16'h55AA);
      i2c_stop();
      i2c_start();
      wr_byte(8'h9A, ack);
      wr_byte(8'h03, ack);
      wr_byte(8'h12, ack);
      i2c_stop();
      check_val("tos_partial", tos_out, 16'h55AA);

      // Temperature read via pointer preset and repeated START
      temp_in = 16'h1900;
      i2c_start();
      wr_byte(8'h9A, ack);
      wr_byte(8'h00, ack); check_val("temp_ptr_ack", {15'd0, ack}, 16'd1);
      i2c_start();
      wr_byte(8'h9B, ack); check_val("temp_rd_ack", {15'd0, ack}, 16'd1);
      rd_byte(1'b1, rd); check_val("temp_msb", {8'h00, rd}, 16'h0019);
      rd_byte(1'b0, rd); check_val("temp_lsb", {8'h00, rd}, 16'h0000);
      check_val("temp_sda_rel", {15'd0, sda}, 16'd1);
      i2c_stop();
      check_val("temp_busy_stop", {15'd0, busy}, 16'd0);

      // Wrong address
      i2c_start();
      wr_byte(8'h90, ack); check_val("badaddr_nack", {15'd0, ack}, 16'd0);
      check_val("badaddr_busy", {15'd0, busy}, 16'd0);
      wr_byte(8'h01, ack);
      wr_byte(8'h00, ack);
      i2c_stop();
      check_val("badaddr_conf", {8'h00, conf_out}, 16'h00CD);
      check_val("badaddr_tos", tos_out, 16'h55AA);

      // Invalid pointer
      i2c_start();
      wr_byte(8'h9A, ack);
      wr_byte(8'h05, ack); check_val("badptr_nack", {15'd0, ack}, 16'd0);
      i2c_stop();

      // Tos read with wrap back to MSB
      i2c_start();
      wr_byte(8'h9A, ack);
      wr_byte(8'h03, ack);
      i2c_start();
      wr_byte(8'h9B, ack);
      rd_byte(1'b1, rd); check_val("tos_rd0", {8'h00, rd}, 16'h0055);
      rd_byte(1'b1, rd); check_val("tos_rd1", {8'h00, rd}, 16'h00AA);
      rd_byte(1'b0, rd); check_val("tos_rd2", {8'h00, rd}, 16'h0055);
      i2c_stop();

      // Conf read returns Conf twice
      i2c_start();
      wr_byte(8'h9A, ack);
      wr_byte(8'h01, ack);
      i2c_start();
      wr_byte(8'h9B, ack);
      rd_byte(1'b1, rd); check_val("conf_rd0", {8'h00, rd}, 16'h00CD);
      rd_byte(1'b0, rd); check_val("conf_rd1", {8'h00, rd}, 16'h00CD);
      i2c_stop();

      // Reset pulse while the target drives Tos MSB bit 7 (=0)
      i2c_start();
      wr_byte(8'h9A, ack);
      wr_byte(8'h03, ack);
      i2c_stop();
      i2c_start();
      wr_byte(8'h9B, ack);
      sda_low = 1'b0; wait_cyc(H/2);
      scl = 1'b1;     wait_cyc(H/2);
      check_val("rstrd_drive", {15'd0, sda}, 16'd0);
      rst = 1'b1; wait_cyc(1);
      rst = 1'b0;
      check_val("rstrd_sda_rel", {15'd0, sda}, 16'd1);
      wait_cyc(H/2);
      scl = 1'b0; wait_cyc(H/2);
      $display("txn: reset mid-read");
      check_val("rstrd_conf", {8'h00, conf_out}, 16'h0000);
      check_val("rstrd_tos", tos_out, 16'h5000);
      check_val("rstrd_busy", {15'd0, busy}, 16'd0);
      i2c_stop();
      i2c_start();
      wr_byte(8'h9B, ack); check_val("post_rst_ack", {15'd0, ack}, 16'd1);
      rd_byte(1'b1, rd); check_val("post_rst_msb", {8'h00, rd}, 16'h0019);
      rd_byte(1'b0, rd); check_val("post_rst_lsb", {8'h00, rd}, 16'h0000);
      i2c_stop();

      // Over-temperature flag
      temp_in = 16'h5100; wait_cyc(5);
`ifdef OS_EN
      check_val("os_set", {15'd0, os}, 16'd1);
      temp_in = 16'h4C00; wait_cyc(5);
      check_val("os_hold", {15'd0, os}, 16'd1);
      temp_in = 16'h4A00; wait_cyc(5);
      check_val("os_clr", {15'd0, os}, 16'd0);
`else
      check_val("os_tied", {15'd0, os}, 16'd0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
